// File: rtl/decoder.sv
// Registered one-hot cell decoder: sel 0..8 -> en1..en9, one cycle latency, no handshake.
// Optional sel_invalid output (sel >= 9) under DECODER_INVALID_EN.
module decoder #(
  parameter int NCELLS = 9,
  parameter int SEL_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  output logic             en1,
  output logic             en2,
  output logic             en3,
  output logic             en4,
  output logic             en5,
  output logic             en6,
  output logic             en7,
  output logic             en8,
  output logic             en9
`ifdef DECODER_INVALID_EN
  ,
  output logic             sel_invalid
`endif
);

  logic [NCELLS-1:0] en_d, en_q;

  // An X/Z sel never matches any cell, so simulation falls back to all-zero enables.
  always_comb begin
    en_d = '0;
    for (int k = 0; k < NCELLS; k++) begin
      if (sel == SEL_W'(k)) begin
        en_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q <= '0;
    end else begin
      en_q <= en_d;
    end
  end

  assign en1 = en_q[0];
  assign en2 = en_q[1];
  assign en3 = en_q[2];
  assign en4 = en_q[3];
  assign en5 = en_q[4];
  assign en6 = en_q[5];
  assign en7 = en_q[6];
  assign en8 = en_q[7];
  assign en9 = en_q[8];

`ifdef DECODER_INVALID_EN
  logic sel_invalid_d, sel_invalid_q;

  always_comb begin
    sel_invalid_d = (sel >= SEL_W'(NCELLS));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_invalid_q <= 1'b0;
    end else begin
      sel_invalid_q <= sel_invalid_d;
    end
  end

  assign sel_invalid = sel_invalid_q;
`endif

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: stimulus pushes expected enables, monitor compares on falling edges.
module tb_decoder;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] sel;
  logic en1, en2, en3, en4, en5, en6, en7, en8, en9;
`ifdef DECODER_INVALID_EN
  logic sel_invalid;
`endif

  decoder dut (
    .clock (clock),
    .reset (reset),
    .sel   (sel),
    .en1   (en1),
    .en2   (en2),
    .en3   (en3),
    .en4   (en4),
    .en5   (en5),
    .en6   (en6),
    .en7   (en7),
    .en8   (en8),
    .en9   (en9)
`ifdef DECODER_INVALID_EN
    ,
    .sel_invalid (sel_invalid)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int         due;
    logic [8:0] en;
    logic       inv;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always @(posedge clock) cyc++;

  // Reference: cell index s enables bit s; anything past the board enables nothing.
  function automatic logic [8:0] model_en(input logic [3:0] s);
    logic [8:0] r;
    r = 9'd0;
    if (s < 4'd9) r = 9'd1 << s;
    return r;
  endfunction

  function automatic logic [8:0] outs();
    return {en9, en8, en7, en6, en5, en4, en3, en2, en1};
  endfunction

  task automatic check_en(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: enables got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_inv(input string name, input logic exp);
`ifdef DECODER_INVALID_EN
    n_cmp++;
    if (sel_invalid !== exp) begin
      n_bad++;
      $display("FAIL %s: sel_invalid got %b expected %b (cycle %0d)", name, sel_invalid, exp, cyc);
    end
`else
    if (exp === 1'bx) $display("unreachable");
`endif
  endtask

  task automatic issue(input logic [3:0] s);
    exp_t e;
    @(posedge clock);
    #2;
    sel = s;
    e.due = cyc + 1;
    e.en  = model_en(s);
    e.inv = (s >= 4'd9);
    q.push_back(e);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset) begin
      n_cmp++;
      if ($countones(outs()) > 1) begin
        n_bad++;
        $display("FAIL onehot: enables got %b required at most one set (cycle %0d)", outs(), cyc);
      end
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stale: entry due cycle %0d got checked at %0d", e.due, cyc);
        end else begin
          check_en("decode", outs(), e.en);
          check_inv("invalid", e.inv);
        end
      end
    end
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    sel   = 4'd0;
    #1;
    check_en("reset_state", outs(), 9'd0);
    check_inv("reset_state_inv", 1'b0);
    @(posedge clock);
    #2 reset = 1'b0;

    // Sweep every legal cell
    for (int s = 0; s < 9; s++) issue(4'(s));

    // Latency: 4 then 7 driven between edges
    issue(4'd4);
    issue(4'd7);

    // Out of range, with legal values around them
    issue(4'd9);
    issue(4'd3);
    issue(4'd12);
    issue(4'd15);
    issue(4'd0);

    // Hold on cell 9
    for (int i = 0; i < 10; i++) issue(4'd8);

    // Back-to-back corners
    for (int i = 0; i < 12; i++) issue((i % 2 == 0) ? 4'd0 : 4'd8);

    // Asynchronous reset mid-cycle with sel=4
    issue(4'd4);
    @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check_en("async_reset", outs(), 9'd0);
    check_inv("async_reset_inv", 1'b0);
    q.delete();
    @(posedge clock);
    #1;
    check_en("reset_held_edge", outs(), 9'd0);
    #1 reset = 1'b0;
    e.due = cyc + 1;
    e.en  = model_en(sel);
    e.inv = 1'b0;
    q.push_back(e);

    // Randomized traffic
    for (int i = 0; i < 200; i++) issue(4'($urandom_range(0, 15)));

    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected responses never checked, required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
